// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetch PC, credit-limited imem requests, in-order response queue, redirect flush.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int          PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          CW      = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_HOLD, S_FETCH, S_DRAIN, S_STALL} state_e;
`else
  typedef enum logic [1:0] {S_HOLD, S_FETCH, S_DRAIN} state_e;
`endif

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   q_cnt_q, q_cnt_d;
  logic [PW-1:0]   tag_rd_q, tag_wr_q, q_rd_q, q_wr_q;
  logic [31:0]     tag_mem_q [QUEUE_DEPTH];
  logic [31:0]     q_instr_q [QUEUE_DEPTH];
  logic [31:0]     q_pc_q    [QUEUE_DEPTH];
  logic            misalign_q, misalign_d;

  logic            credit_ok, req_fire, rsp_take, flush, pop, redir_misaligned;

  // Requests in flight plus queued entries may never exceed the queue size.
  assign credit_ok = ({1'b0, out_cnt_q} + {1'b0, q_cnt_q}) < DEPTH_W;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign imem_req_addr = {fetch_pc_q[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_misaligned = misalign_q;
`else
  logic unused_pc_lsbs;
  assign redir_misaligned = 1'b0;
  assign unused_pc_lsbs   = ^redirect_pc[1:0];
`endif

  assign instr_valid = (q_cnt_q != '0);
  assign instr       = instr_valid ? q_instr_q[q_rd_q] : NOP;
  assign instr_pc    = instr_valid ? q_pc_q[q_rd_q]    : 32'h0;
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    drop_cnt_d     = drop_cnt_q;
    misalign_d     = misalign_q;
    imem_req_valid = 1'b0;
    rsp_take       = 1'b0;
    flush          = 1'b0;
    case (state_q)
      S_HOLD:  state_d = S_FETCH;
      S_FETCH: begin
        imem_req_valid = credit_ok && !redirect_valid;
        rsp_take       = imem_rsp_valid && !redirect_valid;
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_q == CW'(1)) state_d = S_FETCH;
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      S_STALL: begin
        if (imem_rsp_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
      end
`endif
      default: state_d = S_HOLD;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (state_q != S_HOLD) begin
        flush = 1'b1;
        // Outstanding requests become stale; a response landing this cycle is one of them.
        drop_cnt_d = drop_cnt_q + out_cnt_q - CW'(imem_rsp_valid);
        state_d    = (drop_cnt_d != '0) ? S_DRAIN : S_FETCH;
      end
`ifdef IFU_MISALIGN_CHECK_EN
      misalign_d = redir_misaligned;
      if (redir_misaligned) state_d = S_STALL;
`endif
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_comb begin
    if (flush) begin
      out_cnt_d = '0;
      q_cnt_d   = '0;
    end else begin
      out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(rsp_take);
      q_cnt_d   = q_cnt_q + CW'(rsp_take) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HOLD;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      q_cnt_q    <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      q_cnt_q    <= q_cnt_d;
      misalign_q <= misalign_d;
      if (flush) begin
        tag_rd_q <= '0;
        tag_wr_q <= '0;
        q_rd_q   <= '0;
        q_wr_q   <= '0;
      end else begin
        if (req_fire) tag_wr_q <= tag_wr_q + PW'(1);
        if (rsp_take) begin
          tag_rd_q <= tag_rd_q + PW'(1);
          q_wr_q   <= q_wr_q + PW'(1);
        end
        if (pop) q_rd_q <= q_rd_q + PW'(1);
      end
    end
  end

  // Storage arrays need no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= imem_req_addr;
    if (rsp_take) begin
      q_instr_q[q_wr_q] <= imem_rsp_data;
      q_pc_q[q_wr_q]    <= tag_mem_q[tag_rd_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_take && ({1'b0, q_cnt_q} == DEPTH_W) && !pop));
      assert (!(imem_rsp_valid && out_cnt_q == '0 && drop_cnt_q == '0 && state_q != S_HOLD));
    end
  end

endmodule
